frame_deserializer: RTL and testbench
=====================================

# frame_deserializer

Display-side receiver for the serialized frame stream produced by the event core. It collects the LSB-first bit stream of one frame plus a trailing checksum and verifies it. Good frames are committed into a stable frame buffer, and the renderer reads decoded laser and per-alien records from that buffer through an indexed port. Rejected frames never disturb the committed buffer.

## Interface
Parameters:
- OBJ_LIMIT, 8: alien slots per frame.
- ALIEN_BITS, 35: bits per alien record.
- FRAME_BITS, 14 + OBJ_LIMIT*ALIEN_BITS: payload bits per frame (derived, not overridden).

Ports:
- clk  input  1  sole clock; all state on posedge clk.
- rst  input  1  asynchronous, active-low reset.
- ser_valid  input  1  ser_data is valid this cycle.
- ser_data  input  1  serial bit, LSB of frame first.
- ser_sof  input  1  qualified by ser_valid; marks this bit as frame bit 0.
- rd_idx  input  $clog2(OBJ_LIMIT)  alien slot to read; 0 is the closest alien.
- laser_active  output  1  committed frame bit 0.
- laser_r  output  4  committed frame bits [4:1].
- laser_deg  output  9  committed frame bits [13:5].
- rd_valid, rd_type[1:0], rd_frame_num[1:0], rd_r[3:0], rd_quad[1:0], rd_x[9:0], rd_y[9:0], rd_dl[1:0], rd_dr[1:0]  output  alien rd_idx fields.
  - Field offsets from base = 14 + rd_idx*35: [0], [2:1], [4:3], [8:5], [10:9], [20:11], [30:21], [32:31], [34:33].
- frame_ready  output  1  one-cycle pulse on commit of a good frame.
- crc_err  output  1  one-cycle pulse on checksum mismatch.
- sync_err  output  1  one-cycle pulse when a frame is aborted by an early sof.
- busy  output  1  high in RECV or CHK.
- frame_cnt  output  8  count of good frames, wraps 255 -> 0.

## Operation
Frame format:
- Serial word is FRAME_BITS payload bits, LSB first, followed by an 8-bit checksum, LSB first.
- Checksum = number of 1 bits in the payload, mod 256.

State machine:
- IDLE: accepted bits are ignored unless ser_sof. On ser_valid & ser_sof:
  - shift in the bit as bit 0;
  - set bit_cnt = 1 and ones = ser_data;
  - go to RECV.
- RECV: each ser_valid bit is stored at position bit_cnt; bit_cnt increments and ones accumulates (8-bit, wraps). When the bit at position FRAME_BITS-1 is accepted, clear bit_cnt and go to CHK.
- CHK: collect 8 checksum bits into chk[7:0] (bit i on the i-th accepted bit). On the 8th bit:
  - if chk == ones: copy the shadow buffer into the committed buffer, pulse frame_ready, increment frame_cnt;
  - otherwise pulse crc_err and leave the committed buffer unchanged.
  - Return to IDLE in either case.
- Early sof: ser_valid & ser_sof in RECV or CHK aborts the current frame and pulses sync_err. The same bit restarts reception as bit 0 of a new frame (bit_cnt = 1, state RECV).
- Idle cycles: cycles with ser_valid=0 hold all state. Gaps of any length inside a frame are legal.
- Receive buffer: the shadow buffer is written in place (bit position = bit_cnt), not shifted. Stale bits from an aborted frame are overwritten by the next frame.
- Read port:
  - laser_* and rd_* are combinational decodes of the committed buffer only.
  - rd_idx >= OBJ_LIMIT returns all-zero fields.
  - No checking of field contents; x range validation belongs downstream.

## Timing
- Reset (rst=0, asynchronous):
  - state IDLE; bit_cnt, ones, chk, frame_cnt = 0;
  - shadow and committed buffers cleared, so laser_active=0 and every rd_valid=0;
  - frame_ready, crc_err, sync_err, busy = 0.
- Reset asserted mid-frame discards the partial frame. The first accepted bit after release is ignored unless it carries sof.
- Commit timing: the committed buffer and frame_cnt update on the same edge that accepts the 8th checksum bit. frame_ready is registered and high for exactly the following cycle, coincident with the new data being visible.
- Minimum frame time is FRAME_BITS+8 accepted bits. A sof in the cycle directly after the last checksum bit starts the next frame with no lost bits.
- crc_err and sync_err are registered, one cycle wide, and mutually exclusive in any cycle.
- busy = (state != IDLE), registered.
- Read latency: 0 cycles from rd_idx to rd_* outputs.

## Test plan
- Single good frame: slot 0 = {valid 1, type 2, r 5, x 320, y 155}, laser {1, 3, 45}, correct checksum.
  - frame_ready pulses once; frame_cnt=1.
  - rd_idx=0 -> rd_x=320, rd_y=155, rd_r=5, rd_type=2.
  - laser_deg=45.
- Corrupted checksum: commit frame A, then send frame B with checksum+1.
  - crc_err pulses; frame_ready stays 0.
  - Outputs still show A; frame_cnt unchanged.
- Early sof: abort after 100 payload bits with sof, then send a full good frame.
  - sync_err pulses once, then frame_ready pulses.
  - Data matches the second frame only.
- Gapped stream: random ser_valid=0 gaps of 0-5 cycles between bits.
  - Result is identical to the ungapped case.
- Back-to-back: three good frames with sof on the cycle directly after each checksum.
  - Three frame_ready pulses, each FRAME_BITS+8 cycles apart; frame_cnt=3.
- Reset mid-frame and wrap:
  - rst=0 at bit 50 -> all outputs 0, busy=0; a subsequent good frame commits.
  - 256 good frames -> frame_cnt wraps to 0.

Source files
------------

// File: rtl/frame_deserializer.sv
// Receives the LSB-first serial frame stream and verifies its popcount checksum. Good frames are committed to a stable buffer.
// Latency: commit on the edge accepting the 8th checksum bit, with frame_ready high the next cycle. The read port is combinational (0 cycles).
// Backpressure: none. ser_valid=0 cycles hold all state, and gaps inside a frame are legal.
// Ports: clk/rst (async active-low); ser_valid/ser_data/ser_sof serial input; rd_idx selects an alien slot;
//        laser_* and rd_* decode the committed buffer; frame_ready/crc_err/sync_err are 1-cycle pulses;
//        busy is high while a frame is in progress; frame_cnt counts good frames and wraps.
module frame_deserializer #(
    parameter int OBJ_LIMIT  = 8,
    parameter int ALIEN_BITS = 35
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         ser_valid,
    input  logic                         ser_data,
    input  logic                         ser_sof,
    input  logic [$clog2(OBJ_LIMIT)-1:0] rd_idx,
    output logic                         laser_active,
    output logic [3:0]                   laser_r,
    output logic [8:0]                   laser_deg,
    output logic                         rd_valid,
    output logic [1:0]                   rd_type,
    output logic [1:0]                   rd_frame_num,
    output logic [3:0]                   rd_r,
    output logic [1:0]                   rd_quad,
    output logic [9:0]                   rd_x,
    output logic [9:0]                   rd_y,
    output logic [1:0]                   rd_dl,
    output logic [1:0]                   rd_dr,
    output logic                         frame_ready,
    output logic                         crc_err,
    output logic                         sync_err,
    output logic                         busy,
    output logic [7:0]                   frame_cnt
);
    localparam int FRAME_BITS = 14 + OBJ_LIMIT * ALIEN_BITS;
    localparam int CW         = $clog2(FRAME_BITS);

    typedef enum logic [1:0] {IDLE, RECV, CHK} state_t;

    state_t                state, state_nxt;
    logic [CW-1:0]         bit_cnt, cnt_nxt, wr_pos;
    logic [7:0]            ones, ones_nxt, chk, chk_nxt;
    logic                  wr_en, commit, crc_nxt, sync_nxt;
    logic [FRAME_BITS-1:0] shadow, committed;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = bit_cnt;
        ones_nxt  = ones;
        chk_nxt   = chk;
        wr_pos    = bit_cnt;
        wr_en     = 1'b0;
        commit    = 1'b0;
        crc_nxt   = 1'b0;
        sync_nxt  = 1'b0;
        if (ser_valid) begin
            if (ser_sof) begin
                // A sof always restarts reception. It counts as an abort only if a frame was in progress.
                sync_nxt  = (state != IDLE);
                wr_en     = 1'b1;
                wr_pos    = '0;
                cnt_nxt   = CW'(1);
                ones_nxt  = {7'd0, ser_data};
                state_nxt = RECV;
            end else begin
                unique case (state)
                    IDLE: ;
                    RECV: begin
                        wr_en    = 1'b1;
                        ones_nxt = ones + {7'd0, ser_data};
                        if (bit_cnt == CW'(FRAME_BITS - 1)) begin
                            cnt_nxt   = '0;
                            state_nxt = CHK;
                        end else begin
                            cnt_nxt = bit_cnt + CW'(1);
                        end
                    end
                    CHK: begin
                        chk_nxt[bit_cnt[2:0]] = ser_data;
                        if (bit_cnt[2:0] == 3'd7) begin
                            // Compare against the fully assembled checksum, including this bit.
                            commit    = (chk_nxt == ones);
                            crc_nxt   = (chk_nxt != ones);
                            cnt_nxt   = '0;
                            state_nxt = IDLE;
                        end else begin
                            cnt_nxt = bit_cnt + CW'(1);
                        end
                    end
                    default: state_nxt = IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_cnt     <= '0;
            ones        <= '0;
            chk         <= '0;
            frame_cnt   <= '0;
            shadow      <= '0;
            committed   <= '0;
            frame_ready <= 1'b0;
            crc_err     <= 1'b0;
            sync_err    <= 1'b0;
            busy        <= 1'b0;
        end else begin
            bit_cnt <= cnt_nxt;
            ones    <= ones_nxt;
            chk     <= chk_nxt;
            // The buffer is written in place, so bits left over from an aborted frame get overwritten.
            if (wr_en) shadow[wr_pos] <= ser_data;
            if (commit) begin
                committed <= shadow;
                frame_cnt <= frame_cnt + 8'd1;
            end
            frame_ready <= commit;
            crc_err     <= crc_nxt;
            sync_err    <= sync_nxt;
            busy        <= (state_nxt != IDLE);
        end
    end

    // The read port decodes only the committed copy, so a frame in flight never shows through.
    logic [ALIEN_BITS-1:0] slots [OBJ_LIMIT];
    logic [ALIEN_BITS-1:0] slot;

    always_comb begin
        for (int i = 0; i < OBJ_LIMIT; i++)
            slots[i] = committed[14 + i * ALIEN_BITS +: ALIEN_BITS];
        slot = '0;
        if (32'(rd_idx) < 32'(OBJ_LIMIT)) slot = slots[rd_idx];
    end

    assign laser_active = committed[0];
    assign laser_r      = committed[4:1];
    assign laser_deg    = committed[13:5];

    assign rd_valid     = slot[0];
    assign rd_type      = slot[2:1];
    assign rd_frame_num = slot[4:3];
    assign rd_r         = slot[8:5];
    assign rd_quad      = slot[10:9];
    assign rd_x         = slot[20:11];
    assign rd_y         = slot[30:21];
    assign rd_dl        = slot[32:31];
    assign rd_dr        = slot[34:33];
endmodule

// File: tb/tb_frame_deserializer.sv
module tb_frame_deserializer;
    localparam int OBJ_LIMIT  = 8;
    localparam int ALIEN_BITS = 35;
    localparam int FRAME_BITS = 14 + OBJ_LIMIT * ALIEN_BITS;
    localparam int FRAME_TIME = FRAME_BITS + 8;

    logic       clk = 1'b0;
    logic       rst, ser_valid, ser_data, ser_sof;
    logic [2:0] rd_idx;
    logic       laser_active, rd_valid, frame_ready, crc_err, sync_err, busy;
    logic [3:0] laser_r, rd_r;
    logic [8:0] laser_deg;
    logic [1:0] rd_type, rd_frame_num, rd_quad, rd_dl, rd_dr;
    logic [9:0] rd_x, rd_y;
    logic [7:0] frame_cnt;

    always #5 clk = ~clk;

    frame_deserializer #(.OBJ_LIMIT(OBJ_LIMIT), .ALIEN_BITS(ALIEN_BITS)) dut (
        .clk(clk), .rst(rst), .ser_valid(ser_valid), .ser_data(ser_data), .ser_sof(ser_sof),
        .rd_idx(rd_idx), .laser_active(laser_active), .laser_r(laser_r), .laser_deg(laser_deg),
        .rd_valid(rd_valid), .rd_type(rd_type), .rd_frame_num(rd_frame_num), .rd_r(rd_r),
        .rd_quad(rd_quad), .rd_x(rd_x), .rd_y(rd_y), .rd_dl(rd_dl), .rd_dr(rd_dr),
        .frame_ready(frame_ready), .crc_err(crc_err), .sync_err(sync_err), .busy(busy),
        .frame_cnt(frame_cnt)
    );

    wire [34:0] rd_all    = {rd_dr, rd_dl, rd_y, rd_x, rd_quad, rd_r, rd_frame_num, rd_type, rd_valid};
    wire [13:0] laser_all = {laser_deg, laser_r, laser_active};

    int vectors = 0;
    int errors  = 0;
    int cyc = 0, fr_pulses = 0, crc_pulses = 0, sync_pulses = 0, both_pulses = 0;
    int fr_cyc[$];
    int exp_cnt = 0;
    logic [FRAME_BITS-1:0] frame_a, frame_b, frame_c;

    always @(posedge clk) cyc++;
    always @(negedge clk) begin
        if (frame_ready) begin fr_pulses++; fr_cyc.push_back(cyc); end
        if (crc_err)  crc_pulses++;
        if (sync_err) sync_pulses++;
        if (crc_err && sync_err) both_pulses++;
    end

    initial begin
        #950000;
        $display("FAIL watchdog: simulation time limit reached, actual cyc=%0d required <95000", cyc);
        $fatal(1, "watchdog");
    end

    function automatic logic [34:0] alien(input logic v, input logic [1:0] t, input logic [1:0] fn,
                                          input logic [3:0] r, input logic [1:0] q, input logic [9:0] x,
                                          input logic [9:0] y, input logic [1:0] dl, input logic [1:0] dr);
        return {dr, dl, y, x, q, r, fn, t, v};
    endfunction

    function automatic logic [FRAME_BITS-1:0] mk_frame(input logic act, input logic [3:0] r, input logic [8:0] deg);
        logic [FRAME_BITS-1:0] f = '0;
        f[0] = act; f[4:1] = r; f[13:5] = deg;
        return f;
    endfunction

    function automatic logic [7:0] csum(input logic [FRAME_BITS-1:0] f);
        int n = 0;
        for (int i = 0; i < FRAME_BITS; i++) if (f[i]) n++;
        return 8'(n);
    endfunction

    task automatic drive(input logic b, input logic sof);
        @(negedge clk); ser_valid = 1'b1; ser_data = b; ser_sof = sof;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(negedge clk); ser_valid = 1'b0; ser_data = 1'b0; ser_sof = 1'b0; end
    endtask

    // Sends nbits of payload; the checksum (plus adj) follows only when the payload is complete.
    task automatic send_frame(input logic [FRAME_BITS-1:0] f, input int nbits, input logic [7:0] adj, input int gmax);
        logic [7:0] c = csum(f) + adj;
        for (int i = 0; i < nbits; i++) begin
            if (i > 0 && gmax > 0) idle($urandom_range(gmax, 0));
            drive(f[i], i == 0);
        end
        if (nbits == FRAME_BITS)
            for (int j = 0; j < 8; j++) begin
                if (gmax > 0) idle($urandom_range(gmax, 0));
                drive(c[j], 1'b0);
            end
    endtask

    task automatic test_reset;
        rst = 1'b0; ser_valid = 1'b0; ser_data = 1'b0; ser_sof = 1'b0; rd_idx = '0;
        idle(2);
        vectors++; if ({frame_ready, crc_err, sync_err, busy} !== 4'b0) begin errors++;
            $display("FAIL reset_pulses: actual %b required 0000", {frame_ready, crc_err, sync_err, busy}); end
        vectors++; if (frame_cnt !== 8'd0) begin errors++;
            $display("FAIL reset_frame_cnt: actual %0d required 0", frame_cnt); end
        vectors++; if (laser_all !== 14'd0) begin errors++;
            $display("FAIL reset_laser: actual %h required 0", laser_all); end
        for (int i = 0; i < OBJ_LIMIT; i++) begin
            rd_idx = 3'(i); #1;
            vectors++; if (rd_all !== 35'd0) begin errors++;
                $display("FAIL reset_slot%0d: actual %h required 0", i, rd_all); end
        end
        @(negedge clk); rst = 1'b1;
        idle(1);
    endtask

    task automatic test_good_frame;
        int fr0 = fr_pulses;
        send_frame(frame_a, FRAME_BITS, 8'd0, 0);
        idle(1); exp_cnt++;
        vectors++; if (frame_ready !== 1'b1) begin errors++;
            $display("FAIL good_frame_ready: actual %b required 1", frame_ready); end
        vectors++; if (frame_cnt !== 8'd1) begin errors++;
            $display("FAIL good_frame_cnt: actual %0d required 1", frame_cnt); end
        rd_idx = 3'd0; #1;
        vectors++; if ({rd_valid, rd_type, rd_r, rd_x, rd_y} !== {1'b1, 2'd2, 4'd5, 10'd320, 10'd155}) begin errors++;
            $display("FAIL good_slot0: actual v%b t%0d r%0d x%0d y%0d required v1 t2 r5 x320 y155",
                     rd_valid, rd_type, rd_r, rd_x, rd_y); end
        vectors++; if ({laser_active, laser_r, laser_deg} !== {1'b1, 4'd3, 9'd45}) begin errors++;
            $display("FAIL good_laser: actual a%b r%0d deg%0d required a1 r3 deg45", laser_active, laser_r, laser_deg); end
        rd_idx = 3'd3; #1;
        vectors++; if ({rd_frame_num, rd_quad, rd_x, rd_y, rd_dl, rd_dr} !== {2'd2, 2'd3, 10'd700, 10'd480, 2'd1, 2'd2}) begin errors++;
            $display("FAIL good_slot3: actual fn%0d q%0d x%0d y%0d dl%0d dr%0d required fn2 q3 x700 y480 dl1 dr2",
                     rd_frame_num, rd_quad, rd_x, rd_y, rd_dl, rd_dr); end
        rd_idx = 3'd7; #1;
        vectors++; if (rd_valid !== 1'b0) begin errors++;
            $display("FAIL good_slot7_empty: actual %b required 0", rd_valid); end
        idle(2);
        vectors++; if (fr_pulses - fr0 !== 1) begin errors++;
            $display("FAIL good_pulse_count: actual %0d required 1", fr_pulses - fr0); end
    endtask

    task automatic test_bad_crc;
        int fr0 = fr_pulses, crc0 = crc_pulses;
        send_frame(frame_b, FRAME_BITS, 8'd1, 0);
        idle(1);
        vectors++; if ({crc_err, frame_ready} !== 2'b10) begin errors++;
            $display("FAIL crc_pulse: actual crc%b ready%b required crc1 ready0", crc_err, frame_ready); end
        idle(2);
        vectors++; if (crc_pulses - crc0 !== 1 || fr_pulses != fr0) begin errors++;
            $display("FAIL crc_counts: actual crc%0d ready%0d required crc1 ready0", crc_pulses - crc0, fr_pulses - fr0); end
        vectors++; if (frame_cnt !== 8'(exp_cnt)) begin errors++;
            $display("FAIL crc_frame_cnt: actual %0d required %0d", frame_cnt, exp_cnt); end
        vectors++; if (laser_all !== frame_a[13:0]) begin errors++;
            $display("FAIL crc_laser_kept: actual %h required %h", laser_all, frame_a[13:0]); end
        for (int i = 0; i < OBJ_LIMIT; i++) begin
            rd_idx = 3'(i); #1;
            vectors++; if (rd_all !== frame_a[14 + i*35 +: 35]) begin errors++;
                $display("FAIL crc_slot%0d_kept: actual %h required %h", i, rd_all, frame_a[14 + i*35 +: 35]); end
        end
    endtask

    task automatic test_early_sof;
        int fr0 = fr_pulses, sy0 = sync_pulses;
        send_frame(frame_b, 100, 8'd0, 0);
        send_frame(frame_c, FRAME_BITS, 8'd0, 0);
        idle(1); exp_cnt++;
        vectors++; if (frame_ready !== 1'b1) begin errors++;
            $display("FAIL sof_ready: actual %b required 1", frame_ready); end
        idle(2);
        vectors++; if (sync_pulses - sy0 !== 1 || fr_pulses - fr0 !== 1) begin errors++;
            $display("FAIL sof_counts: actual sync%0d ready%0d required sync1 ready1", sync_pulses - sy0, fr_pulses - fr0); end
        vectors++; if (laser_all !== frame_c[13:0] || frame_cnt !== 8'(exp_cnt)) begin errors++;
            $display("FAIL sof_laser_cnt: actual %h/%0d required %h/%0d", laser_all, frame_cnt, frame_c[13:0], exp_cnt); end
        for (int i = 0; i < OBJ_LIMIT; i++) begin
            rd_idx = 3'(i); #1;
            vectors++; if (rd_all !== frame_c[14 + i*35 +: 35]) begin errors++;
                $display("FAIL sof_slot%0d: actual %h required %h", i, rd_all, frame_c[14 + i*35 +: 35]); end
        end
    endtask

    task automatic test_gapped;
        int fr0 = fr_pulses;
        send_frame(frame_a, FRAME_BITS, 8'd0, 5);
        idle(3); exp_cnt++;
        vectors++; if (fr_pulses - fr0 !== 1 || frame_cnt !== 8'(exp_cnt)) begin errors++;
            $display("FAIL gap_commit: actual ready%0d cnt%0d required ready1 cnt%0d", fr_pulses - fr0, frame_cnt, exp_cnt); end
        vectors++; if (laser_all !== frame_a[13:0]) begin errors++;
            $display("FAIL gap_laser: actual %h required %h", laser_all, frame_a[13:0]); end
        for (int i = 0; i < OBJ_LIMIT; i++) begin
            rd_idx = 3'(i); #1;
            vectors++; if (rd_all !== frame_a[14 + i*35 +: 35]) begin errors++;
                $display("FAIL gap_slot%0d: actual %h required %h", i, rd_all, frame_a[14 + i*35 +: 35]); end
        end
    endtask

    task automatic test_back_to_back;
        fr_cyc.delete();
        send_frame(frame_a, FRAME_BITS, 8'd0, 0);
        send_frame(frame_c, FRAME_BITS, 8'd0, 0);
        send_frame(frame_a, FRAME_BITS, 8'd0, 0);
        idle(3); exp_cnt += 3;
        vectors++; if (fr_cyc.size() !== 3) begin errors++;
            $display("FAIL b2b_pulses: actual %0d required 3", fr_cyc.size()); end
        else begin
            vectors++; if (fr_cyc[1] - fr_cyc[0] !== FRAME_TIME || fr_cyc[2] - fr_cyc[1] !== FRAME_TIME) begin errors++;
                $display("FAIL b2b_spacing: actual %0d,%0d required %0d", fr_cyc[1] - fr_cyc[0], fr_cyc[2] - fr_cyc[1], FRAME_TIME); end
        end
        vectors++; if (frame_cnt !== 8'(exp_cnt) || laser_all !== frame_a[13:0]) begin errors++;
            $display("FAIL b2b_cnt_laser: actual %0d/%h required %0d/%h", frame_cnt, laser_all, exp_cnt, frame_a[13:0]); end
    endtask

    task automatic test_reset_mid_and_wrap;
        int fr0;
        send_frame(frame_c, 50, 8'd0, 0);
        idle(1);
        vectors++; if (busy !== 1'b1) begin errors++;
            $display("FAIL mid_busy: actual %b required 1", busy); end
        #2 rst = 1'b0; #1;
        exp_cnt = 0;
        vectors++; if ({busy, frame_ready, laser_all, frame_cnt} !== 24'd0) begin errors++;
            $display("FAIL mid_reset_outputs: actual busy%b ready%b laser%h cnt%0d required all 0",
                     busy, frame_ready, laser_all, frame_cnt); end
        for (int i = 0; i < OBJ_LIMIT; i++) begin
            rd_idx = 3'(i); #1;
            vectors++; if (rd_all !== 35'd0) begin errors++;
                $display("FAIL mid_reset_slot%0d: actual %h required 0", i, rd_all); end
        end
        idle(2); rst = 1'b1;
        // Bits without sof after release must be ignored.
        repeat (10) drive(1'b1, 1'b0);
        idle(2);
        vectors++; if (busy !== 1'b0) begin errors++;
            $display("FAIL mid_ignore_nosof: actual busy %b required 0", busy); end
        send_frame(frame_a, FRAME_BITS, 8'd0, 0);
        idle(2); exp_cnt++;
        vectors++; if (frame_cnt !== 8'(exp_cnt) || laser_all !== frame_a[13:0]) begin errors++;
            $display("FAIL mid_recommit: actual %0d/%h required %0d/%h", frame_cnt, laser_all, exp_cnt, frame_a[13:0]); end
        fr0 = fr_pulses;
        for (int k = 0; k < 255; k++) send_frame((k % 2 == 0) ? frame_c : frame_b, FRAME_BITS, 8'd0, 0);
        idle(3); exp_cnt = (exp_cnt + 255) % 256;
        vectors++; if (frame_cnt !== 8'(exp_cnt)) begin errors++;
            $display("FAIL wrap_cnt: actual %0d required %0d", frame_cnt, exp_cnt); end
        vectors++; if (fr_pulses - fr0 !== 255 || laser_all !== frame_c[13:0]) begin errors++;
            $display("FAIL wrap_pulses: actual %0d/%h required 255/%h", fr_pulses - fr0, laser_all, frame_c[13:0]); end
        vectors++; if (both_pulses !== 0) begin errors++;
            $display("FAIL err_exclusive: actual %0d overlapping cycles required 0", both_pulses); end
    endtask

    initial begin
        frame_a = mk_frame(1'b1, 4'd3, 9'd45);
        frame_a[14 + 0*35 +: 35] = alien(1'b1, 2'd2, 2'd0, 4'd5, 2'd0, 10'd320, 10'd155, 2'd0, 2'd0);
        frame_a[14 + 3*35 +: 35] = alien(1'b1, 2'd1, 2'd2, 4'd9, 2'd3, 10'd700, 10'd480, 2'd1, 2'd2);
        frame_b = mk_frame(1'b1, 4'd15, 9'd511);
        frame_b[14 + 0*35 +: 35] = alien(1'b1, 2'd3, 2'd3, 4'd15, 2'd3, 10'd1023, 10'd1023, 2'd3, 2'd3);
        frame_b[14 + 1*35 +: 35] = '1;
        frame_b[14 + 6*35 +: 35] = alien(1'b1, 2'd0, 2'd1, 4'd2, 2'd1, 10'd10, 10'd20, 2'd2, 2'd0);
        frame_c = mk_frame(1'b0, 4'd6, 9'd90);
        frame_c[14 + 0*35 +: 35] = alien(1'b1, 2'd3, 2'd1, 4'd2, 2'd1, 10'd17, 10'd40, 2'd0, 2'd1);
        frame_c[14 + 7*35 +: 35] = alien(1'b1, 2'd0, 2'd3, 4'd12, 2'd2, 10'd639, 10'd1, 2'd3, 2'd0);
        test_reset;
        test_good_frame;
        test_bad_crc;
        test_early_sof;
        test_gapped;
        test_back_to_back;
        test_reset_mid_and_wrap;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
